// File: rtl/reg_bank_write_arbiter.sv
// reg_bank_write_arbiter
//   Round-robin arbiter that shares one write path into a bank of NREG
//   registers among NREQ requesters. The winner's address is decoded into
//   a one-hot write enable, which is registered together with the data.
//
// Ports
//   i_clk, i_rst_n  clock (rising edge), synchronous active-low reset
//   i_req_valid     per-requester write request
//   i_req_addr      packed addresses, requester k at [k*AW +: AW]
//   i_req_data      packed data, requester k at [k*WIDTH +: WIDTH]
//   o_req_ready     one-hot grant (combinational), gated off during reset
//   o_we            one-hot bank write enable (registered)
//   o_wdata         bank write data (registered, holds when idle)
//   o_grant_id      requester index behind o_we/o_wdata (registered, holds)
//   o_err           one-cycle pulse: accepted address was >= NREG
//   o_busy          more than one requester was valid in the grant cycle
module reg_bank_write_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int NREG  = 8,
  parameter  int WIDTH = 32,
  parameter  int AW    = 3,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NREQ-1:0]       i_req_valid,
  input  logic [NREQ*AW-1:0]    i_req_addr,
  input  logic [NREQ*WIDTH-1:0] i_req_data,
  output logic [NREQ-1:0]       o_req_ready,
  output logic [NREG-1:0]       o_we,
  output logic [WIDTH-1:0]      o_wdata,
  output logic [IDW-1:0]        o_grant_id,
  output logic                  o_err,
  output logic                  o_busy
);

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [NREG-1:0]  we_q, we_d;
  logic [WIDTH-1:0] wdata_q;
  logic [IDW-1:0]   gid_q;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  logic             found;
  logic [IDW-1:0]   gidx;
  logic             accept;
  logic [AW-1:0]    sel_addr;
  logic [WIDTH-1:0] sel_data;

  // Search from ptr upward, wrapping; first valid index wins.
  always_comb begin
    int idx;
    found = 1'b0;
    gidx  = '0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && i_req_valid[idx]) begin
        found = 1'b1;
        gidx  = IDW'(idx);
      end
    end
  end

  // Ready is forced low in reset so nothing is handshaken and then dropped.
  assign accept = found & i_rst_n;

  always_comb begin
    o_req_ready = '0;
    if (accept) o_req_ready[gidx] = 1'b1;
  end

  assign sel_addr = i_req_addr[int'(gidx)*AW +: AW];
  assign sel_data = i_req_data[int'(gidx)*WIDTH +: WIDTH];

  // Decode; an out-of-range address leaves the enable all-zero and flags err.
  always_comb begin
    int cnt;
    cnt    = 0;
    we_d   = '0;
    err_d  = 1'b0;
    busy_d = 1'b0;
    ptr_d  = ptr_q;
    for (int k = 0; k < NREQ; k++) cnt = cnt + int'(i_req_valid[k]);
    if (accept) begin
      for (int r = 0; r < NREG; r++) we_d[r] = (sel_addr == AW'(r));
      err_d  = ~|we_d;
      busy_d = (cnt > 1);
      ptr_d  = (gidx == IDW'(NREQ-1)) ? '0 : gidx + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ptr_q   <= '0;
      we_q    <= '0;
      wdata_q <= '0;
      gid_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      we_q   <= we_d;
      err_q  <= err_d;
      busy_q <= busy_d;
      // Data and id hold across idle cycles.
      if (accept) begin
        wdata_q <= sel_data;
        gid_q   <= gidx;
      end
    end
  end

  assign o_we       = we_q;
  assign o_wdata    = wdata_q;
  assign o_grant_id = gid_q;
  assign o_err      = err_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// Bench for reg_bank_write_arbiter (NREQ=4, NREG=6, WIDTH=32, AW=3).
// A reference model predicts ready each cycle and pushes the expected
// registered outputs; they are popped and compared after the edge.
module tb_reg_bank_write_arbiter;
  localparam int NREQ = 4, NREG = 6, WIDTH = 32, AW = 3;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic [NREG-1:0]       we;
  logic [WIDTH-1:0]      wdata;
  logic [1:0]            grant_id;
  logic                  err, busy;

  reg_bank_write_arbiter #(.NREQ(NREQ), .NREG(NREG), .WIDTH(WIDTH), .AW(AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_addr(req_addr),
    .i_req_data(req_data), .o_req_ready(req_ready), .o_we(we), .o_wdata(wdata),
    .o_grant_id(grant_id), .o_err(err), .o_busy(busy));

  always #5 clk = ~clk;

  typedef struct {
    logic [NREG-1:0]  we;
    logic [WIDTH-1:0] wdata;
    logic [1:0]       gid;
    logic             err;
    logic             busy;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0, n_err = 0;

  // model state
  int              mptr = 0;
  logic [WIDTH-1:0] mwd = '0;
  logic [1:0]      mgid = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, predict + check ready, push expectation, clock, pop + check.
  task automatic step(input logic [3:0] v, input logic [11:0] a, input logic [127:0] d,
                      input logic rst, input bit late_rst);
    exp_t e;
    int   g;
    logic [NREQ-1:0] rdy;
    logic [AW-1:0]   ga;
    rst_n = rst; req_valid = v; req_addr = a; req_data = d;
    #2;
    g = -1;
    for (int i = 0; i < NREQ; i++)
      if (g < 0 && v[(mptr + i) % NREQ]) g = (mptr + i) % NREQ;
    rdy = '0;
    if (rst && g >= 0) rdy[g] = 1'b1;
    chk("ready", 64'(req_ready), 64'(rdy));
    if (late_rst) begin
      rst_n = 1'b0;
      #1;
      chk("ready_rst", 64'(req_ready), 64'(0));
    end
    if (!rst || late_rst) begin
      e = '{we: '0, wdata: '0, gid: '0, err: 1'b0, busy: 1'b0};
      mptr = 0; mwd = '0; mgid = '0;
    end else if (g >= 0) begin
      ga = a[g*AW +: AW];
      e.we    = (int'(ga) < NREG) ? (NREG'(1) << ga) : '0;
      e.err   = (int'(ga) >= NREG);
      e.wdata = d[g*WIDTH +: WIDTH];
      e.gid   = 2'(g);
      e.busy  = ($countones(v) > 1);
      mptr = (g + 1) % NREQ; mwd = e.wdata; mgid = e.gid;
    end else begin
      e = '{we: '0, wdata: mwd, gid: mgid, err: 1'b0, busy: 1'b0};
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("we",    64'(we),       64'(e.we));
    chk("wdata", 64'(wdata),    64'(e.wdata));
    chk("gid",   64'(grant_id), 64'(e.gid));
    chk("err",   64'(err),      64'(e.err));
    chk("busy",  64'(busy),     64'(e.busy));
  endtask

  localparam logic [11:0]  A_K = {3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [127:0] D_K = {32'd3, 32'd2, 32'd1, 32'd0};

  initial begin
    logic [11:0]  a;
    logic [127:0] d;
    rst_n = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    @(posedge clk); #1;
    // reset with everyone requesting
    step(4'hF, A_K, D_K, 1'b0, 1'b0);
    step(4'hF, A_K, D_K, 1'b0, 1'b0);
    // first grant after release -> requester 0
    step(4'hF, A_K, D_K, 1'b1, 1'b0);
    step(4'h0, '0, '0, 1'b1, 1'b0);
    // single requester 1, addr 5
    a = '0; a[1*AW +: AW] = 3'd5;
    d = '0; d[1*WIDTH +: WIDTH] = 32'hDEADBEEF;
    step(4'b0010, a, d, 1'b1, 1'b0);
    step(4'h0, '0, '0, 1'b1, 1'b0);
    // park pointer at 0 via requester 3
    step(4'b1000, A_K, D_K, 1'b1, 1'b0);
    // round robin, all four valid
    for (int c = 0; c < 8; c++) step(4'hF, A_K, D_K, 1'b1, 1'b0);
    // out-of-range: requester 2 addr 7, pointer -> 3
    a = '0; a[2*AW +: AW] = 3'd7;
    d = '0; d[2*WIDTH +: WIDTH] = 32'h0BAD_0007;
    step(4'b0100, a, d, 1'b1, 1'b0);
    // wrap: requester 3 at ptr 3, then 0 and 3 contend
    step(4'b1000, A_K, D_K, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) step(4'b1001, A_K, D_K, 1'b1, 1'b0);
    step(4'h0, '0, '0, 1'b1, 1'b0);
    // reset lands before requester 0 (addr 2) handshakes; pointer was 1
    a = '0; a[0 +: AW] = 3'd2;
    d = '0; d[0 +: WIDTH] = 32'h2222_2222;
    step(4'b0001, a, d, 1'b1, 1'b1);
    // pointer back at 0
    step(4'hF, A_K, D_K, 1'b1, 1'b0);
    // random traffic including out-of-range addresses
    for (int c = 0; c < 60; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        a[k*AW +: AW]       = 3'($urandom_range(0, 7));
        d[k*WIDTH +: WIDTH] = $urandom;
      end
      step(4'($urandom_range(0, 15)), a, d, 1'b1, 1'b0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule

// File: doc/reg_bank_write_arbiter.md
Name: reg_bank_write_arbiter

Overview:
- Round-robin write arbiter and write-enable sequencer for a bank of NREG write-enabled data registers.
- Shares a single write path among NREQ requesters.
- Per cycle, selects one requester and decodes its address into a one-hot per-register write enable.
- Drives the bank's enable and data inputs from a registered output stage.

Parameters:
- NREQ, 4, number of requesters (2..8)
- NREG, 8, number of registers in the bank (2..16)
- WIDTH, 32, register data width
- AW, 3, address width; must satisfy 2**AW >= NREG

Ports:
- i_clk  input  1  clock; all logic on rising edge
- i_rst_n  input  1  reset, synchronous, active-low
- i_req_valid  input  NREQ  per-requester write request
- i_req_addr  input  NREQ*AW  packed addresses; requester k occupies bits [k*AW +: AW]
- i_req_data  input  NREQ*WIDTH  packed data; requester k occupies bits [k*WIDTH +: WIDTH]
- o_req_ready  output  NREQ  one-hot grant, combinational; handshake completes on valid & ready at a clock edge
- o_we  output  NREG  one-hot write enable to the bank, registered
- o_wdata  output  WIDTH  write data to the bank, registered
- o_grant_id  output  clog2(NREQ)  index of requester whose write is on o_we/o_wdata, registered
- o_err  output  1  one-cycle pulse: accepted write had address >= NREG, registered
- o_busy  output  1  high when more than one requester was valid in the arbitration cycle, registered

Behaviour:
- Reset: i_rst_n sampled low at a rising edge sets the following to 0: rr pointer, o_we, o_wdata, o_grant_id, o_err, o_busy.
- While i_rst_n is low, o_req_ready is forced to 0 (combinationally gated), so no handshake completes.
- Arbitration (combinational):
  - Search i_req_valid starting at index ptr, ascending, wrapping modulo NREQ.
  - The first valid index g gets o_req_ready[g]=1; all other ready bits are 0.
  - If no requester is valid, o_req_ready=0.
- Pointer update: on an accepted handshake, ptr <= (g+1) mod NREQ, wrapping NREQ-1 -> 0. With no request, ptr holds.
- Issue stage (one cycle latency), in the cycle after acceptance:
  - o_we = one-hot of the accepted address.
  - o_wdata = accepted data.
  - o_grant_id = g.
  - The bank captures on the following edge.
- Idle cycle (no acceptance): o_we=0, o_err=0, o_busy=0; o_wdata and o_grant_id hold their last values.
- At most one bit of o_we is ever set. Back-to-back acceptances give o_we pulses on consecutive cycles, sustaining one write per cycle.
- Out-of-range address (addr >= NREG):
  - Still accepted and the pointer advances.
  - Next cycle: o_we=0, o_err=1 for one cycle, o_grant_id=g, o_wdata=accepted data.
- Requester rules:
  - Hold valid, addr and data stable until ready is seen.
  - Dropping valid before ready is legal and withdraws the request; no write is issued.
- Starvation bound: a continuously valid requester is granted within NREQ cycles.
- Reset mid-operation: a write accepted in the cycle before a reset edge is dropped (o_we=0 after that edge). The pointer returns to 0.
- No storage other than: pointer, output registers, o_err, o_busy.

Test Plan:
- Reset: hold i_rst_n=0 for 2 edges with all i_req_valid=1 -> o_req_ready=0000, o_we=0, o_wdata=0, o_err=0. First grant after release goes to requester 0.
- Single requester: req1 valid, addr=5, data=0xDEADBEEF -> ready=0010 that cycle. Next cycle o_we=0x20, o_wdata=0xDEADBEEF, o_grant_id=1. Then o_we=0.
- Round-robin: all four valid for 8 cycles, addr=k, data=k -> grant order 0,1,2,3,0,1,2,3; o_we sequence 01,02,04,08 repeating, one cycle delayed; o_busy=1 throughout.
- Wrap/fairness: req3 valid first with ptr=3, then req0 and req3 continuously -> grants 3,0,3,0; neither requester waits more than NREQ cycles.
- Out-of-range: NREG=6, req2 writes addr=7 -> accepted. Next cycle o_we=0, o_err=1, o_grant_id=2; ptr advances to 3.
- Reset mid-operation: accept req0 addr=2, assert i_rst_n=0 on the next edge -> o_we never shows 0x04; ptr=0 after reset.
